mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sitting in front of the shared single-port memory model. Shares the memory between the instruction-fetch port (IFU, read-only) and the load/store port (LSU, read/write). Grants one request per cycle, round-robin. Returns each response through a per-port valid/ready channel with a hold buffer, so a stalled requester never loses read data when the memory output register is overwritten.

## Interface
- ADDR_W, 32, address width, passed through unchanged
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_ifu_req_valid  in  1  IFU read request
- o_ifu_req_ready  out  1  IFU request granted this cycle
- i_ifu_addr  in  ADDR_W  IFU read address
- o_ifu_rsp_valid  out  1  IFU read data valid
- i_ifu_rsp_ready  in  1  IFU accepts response
- o_ifu_rsp_data  out  DATA_W  IFU read data
- i_lsu_req_valid  in  1  LSU request
- o_lsu_req_ready  out  1  LSU request granted this cycle
- i_lsu_addr  in  ADDR_W  LSU address
- i_lsu_wr_data  in  DATA_W  LSU write data
- i_lsu_wr_en  in  DATA_W/8  byte enables; all-zero means read
- o_lsu_rsp_valid  out  1  LSU response (read data or write ack)
- i_lsu_rsp_ready  in  1  LSU accepts response
- o_lsu_rsp_data  out  DATA_W  read data; 0 for write acks
- o_mem_addr, o_mem_wr_data, o_mem_wr_en, o_mem_rd_en  out  ADDR_W, DATA_W, DATA_W/8, 1  memory command
- i_mem_rd_data  in  DATA_W  memory registered read data, valid one cycle after the read command

## Operation
- **Eligibility.** A port is eligible when req_valid=1 and its response slot is free. A slot is free when it is IDLE, or when it holds a response that is accepted this cycle (rsp_valid && rsp_ready).
- **Arbitration** is combinational in cycle N:
  - one eligible port: it wins;
  - both eligible: the port not in last_grant wins.
  - last_grant updates only on a grant. Its reset value is LSU, so IFU wins the first tie.
- **Handshake.** The winner's req_ready=1 and the handshake completes in cycle N. req_ready is never asserted to a non-valid or ineligible port.
- **Memory command.** The memory command is driven combinationally from the winner.
  - IFU winner: rd_en=1, wr_en=0.
  - LSU winner: wr_en=i_lsu_wr_en, rd_en=~|i_lsu_wr_en.
  - No grant: addr, wr_data, wr_en and rd_en are all 0.
- **Per-port response slot FSM** (states IDLE, FRESH, HELD):
  - **IDLE→FRESH**: on the clock edge following a grant.
  - **FRESH**: rsp_valid=1. rsp_data is i_mem_rd_data for a read, 0 for a write.
    - ready=1: go to IDLE, or stay FRESH if the port is regranted this cycle.
    - ready=0: latch rsp_data into the hold register and go to HELD.
  - **HELD**: rsp_valid=1, rsp_data comes from the hold register. On ready, go to IDLE, or to FRESH if regranted.
  - The slot records whether the pending operation is a read or a write.
- Addresses, byte order and alignment are passed through untouched. The arbiter performs no checks.

## Timing
- Request accept → response valid: exactly 1 cycle (memory read latency).
- Peak throughput is 1 grant per cycle. A single port can issue back-to-back only if it accepts each response in its FRESH cycle.
- rsp_ready → req_ready is a combinational path; this is intentional.
- Other port's grant while this slot is FRESH and stalled: the hold latch at the end of FRESH preserves this port's data before the memory output changes.
- Both ports valid every cycle with both responses accepted immediately: grants strictly alternate IFU, LSU, IFU, …
- Reset values: all rsp_valid=0, rsp_data=0, req_ready=0, memory command outputs 0, slots IDLE, hold registers 0, last_grant=LSU.
- Reset asserted mid-operation: in-flight responses are dropped, with no completion after reset release.

## Structure
- Package mem_arb_pkg:
  - typedef enum rsp_state_e {IDLE, FRESH, HELD};
  - typedef enum req_id_e {REQ_IFU, REQ_LSU};
  - localparams for the default widths.
- Sub-module mem_arb_rsp_slot holds one response FSM, the read/write flag and the hold register; it is instantiated once per port.
- Top level holds the arbitration logic, last_grant and the command mux.

## Test plan
- **Single IFU read.** Preload word 0x10 = 0xDEADBEEF; IFU read 0x10 with rsp_ready=1.
  - Expect: grant same cycle; next cycle rsp_valid=1 with data equal to memory read data for 0x10.
- **LSU write then read.** LSU write 0xCAFEF00D to 0x20, wr_en=4'hF, then LSU read 0x20.
  - Expect: write ack with data 0 one cycle later; the read returns the memory contents of 0x20.
- **Simultaneous requests.** Both ports valid from reset for 4 cycles, responses always accepted.
  - Expect: grant order IFU, LSU, IFU, LSU; mem_rd_en/wr_en follow the winner each cycle.
- **Backpressure.** IFU read 0x10 with rsp_ready=0 for 3 cycles while LSU reads 0x20 back-to-back.
  - Expect: IFU data stays at the 0x10 value throughout (HELD); IFU is not regranted until it accepts; LSU continues unaffected.
- **Reset mid-operation.** Assert rst_n=0 in the FRESH cycle of a pending LSU read.
  - Expect: all outputs 0 immediately; no response after release; first tie goes to IFU.
- **Idle bus.** No requests for 10 cycles.
  - Expect: o_mem_rd_en=0, o_mem_wr_en=0, o_mem_addr=0; memory contents unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } rsp_state_e;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_rsp_slot.sv
// One per-port response slot: tracks the outstanding operation and keeps the
// read data in a hold register if the requester stalls.
module mem_arb_rsp_slot
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              grant_i,
  input  logic              grant_rd_i,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  input  logic              rsp_ready_i,
  output rsp_state_e        state_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o
);

  rsp_state_e        state_q, state_d;
  logic              is_rd_q, is_rd_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] fresh_data;

  // Valid/ready: a response transfers in any cycle where rsp_valid_o and
  // rsp_ready_i are both high; rsp_valid_o never drops before that transfer.
  always_comb begin
    state_d     = state_q;
    is_rd_d     = is_rd_q;
    hold_d      = hold_q;
    rsp_valid_o = 1'b0;
    rsp_data_o  = '0;
    fresh_data  = is_rd_q ? mem_rd_data_i : '0;

    if (grant_i) begin
      is_rd_d = grant_rd_i;
    end

    case (state_q)
      IDLE: begin
        if (grant_i) state_d = FRESH;
      end
      FRESH: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = fresh_data;
        if (rsp_ready_i) begin
          state_d = grant_i ? FRESH : IDLE;
        end else begin
          // Capture now: the memory output register may change next cycle.
          hold_d  = fresh_data;
          state_d = HELD;
        end
      end
      HELD: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = hold_q;
        if (rsp_ready_i) begin
          state_d = grant_i ? FRESH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      is_rd_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      is_rd_q <= is_rd_d;
      hold_q  <= hold_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the IFU (read)
// and LSU (read/write) ports, with a per-port buffered response channel.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_ifu_req_valid,
  output logic                o_ifu_req_ready,
  input  logic [ADDR_W-1:0]   i_ifu_addr,
  output logic                o_ifu_rsp_valid,
  input  logic                i_ifu_rsp_ready,
  output logic [DATA_W-1:0]   o_ifu_rsp_data,
  input  logic                i_lsu_req_valid,
  output logic                o_lsu_req_ready,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic [DATA_W-1:0]   i_lsu_wr_data,
  input  logic [DATA_W/8-1:0] i_lsu_wr_en,
  output logic                o_lsu_rsp_valid,
  input  logic                i_lsu_rsp_ready,
  output logic [DATA_W-1:0]   o_lsu_rsp_data,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wr_data,
  output logic [DATA_W/8-1:0] o_mem_wr_en,
  output logic                o_mem_rd_en,
  input  logic [DATA_W-1:0]   i_mem_rd_data
);

  req_id_e    last_grant_q, last_grant_d;
  rsp_state_e ifu_state, lsu_state;
  logic       ifu_free, lsu_free, ifu_elig, lsu_elig;
  logic       ifu_win, lsu_win, lsu_is_rd;

  assign lsu_is_rd = ~|i_lsu_wr_en;

  // A slot can take a new request if empty or if its response leaves this cycle;
  // this makes rsp_ready -> req_ready a deliberate combinational path.
  assign ifu_free = (ifu_state == IDLE) || (o_ifu_rsp_valid && i_ifu_rsp_ready);
  assign lsu_free = (lsu_state == IDLE) || (o_lsu_rsp_valid && i_lsu_rsp_ready);

  always_comb begin
    ifu_elig      = rst_n && i_ifu_req_valid && ifu_free;
    lsu_elig      = rst_n && i_lsu_req_valid && lsu_free;
    ifu_win       = 1'b0;
    lsu_win       = 1'b0;
    last_grant_d  = last_grant_q;
    o_mem_addr    = '0;
    o_mem_wr_data = '0;
    o_mem_wr_en   = '0;
    o_mem_rd_en   = 1'b0;

    if (ifu_elig && lsu_elig) begin
      ifu_win = (last_grant_q == REQ_LSU);
      lsu_win = (last_grant_q == REQ_IFU);
    end else begin
      ifu_win = ifu_elig;
      lsu_win = lsu_elig;
    end

    if (ifu_win) begin
      last_grant_d = REQ_IFU;
      o_mem_addr   = i_ifu_addr;
      o_mem_rd_en  = 1'b1;
    end else if (lsu_win) begin
      last_grant_d  = REQ_LSU;
      o_mem_addr    = i_lsu_addr;
      o_mem_wr_data = i_lsu_wr_data;
      o_mem_wr_en   = i_lsu_wr_en;
      o_mem_rd_en   = lsu_is_rd;
    end
  end

  assign o_ifu_req_ready = ifu_win;
  assign o_lsu_req_ready = lsu_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= REQ_LSU;
    else        last_grant_q <= last_grant_d;
  end

  mem_arb_rsp_slot #(.DATA_W(DATA_W)) u_ifu_slot (
    .clk           (clk),
    .rst_n         (rst_n),
    .grant_i       (ifu_win),
    .grant_rd_i    (1'b1),
    .mem_rd_data_i (i_mem_rd_data),
    .rsp_ready_i   (i_ifu_rsp_ready),
    .state_o       (ifu_state),
    .rsp_valid_o   (o_ifu_rsp_valid),
    .rsp_data_o    (o_ifu_rsp_data)
  );

  mem_arb_rsp_slot #(.DATA_W(DATA_W)) u_lsu_slot (
    .clk           (clk),
    .rst_n         (rst_n),
    .grant_i       (lsu_win),
    .grant_rd_i    (lsu_is_rd),
    .mem_rd_data_i (i_mem_rd_data),
    .rsp_ready_i   (i_lsu_rsp_ready),
    .state_o       (lsu_state),
    .rsp_valid_o   (o_lsu_rsp_valid),
    .rsp_data_o    (o_lsu_rsp_data)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, directed and random stimulus, and a
// scoreboard fed by a transaction-level reference of the arbitration rules.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_ifu_req_valid = 1'b0, i_ifu_rsp_ready = 1'b0;
  logic [AW-1:0] i_ifu_addr = '0;
  logic          i_lsu_req_valid = 1'b0, i_lsu_rsp_ready = 1'b0;
  logic [AW-1:0] i_lsu_addr = '0;
  logic [DW-1:0] i_lsu_wr_data = '0;
  logic [BW-1:0] i_lsu_wr_en = '0;
  logic [DW-1:0] i_mem_rd_data = '0;
  logic          o_ifu_req_ready, o_ifu_rsp_valid, o_lsu_req_ready, o_lsu_rsp_valid;
  logic [DW-1:0] o_ifu_rsp_data, o_lsu_rsp_data, o_mem_wr_data;
  logic [AW-1:0] o_mem_addr;
  logic [BW-1:0] o_mem_wr_en;
  logic          o_mem_rd_en;

  int n_err = 0;
  int n_checks = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ifu_req_valid(i_ifu_req_valid), .o_ifu_req_ready(o_ifu_req_ready),
    .i_ifu_addr(i_ifu_addr), .o_ifu_rsp_valid(o_ifu_rsp_valid),
    .i_ifu_rsp_ready(i_ifu_rsp_ready), .o_ifu_rsp_data(o_ifu_rsp_data),
    .i_lsu_req_valid(i_lsu_req_valid), .o_lsu_req_ready(o_lsu_req_ready),
    .i_lsu_addr(i_lsu_addr), .i_lsu_wr_data(i_lsu_wr_data), .i_lsu_wr_en(i_lsu_wr_en),
    .o_lsu_rsp_valid(o_lsu_rsp_valid), .i_lsu_rsp_ready(i_lsu_rsp_ready),
    .o_lsu_rsp_data(o_lsu_rsp_data),
    .o_mem_addr(o_mem_addr), .o_mem_wr_data(o_mem_wr_data), .o_mem_wr_en(o_mem_wr_en),
    .o_mem_rd_en(o_mem_rd_en), .i_mem_rd_data(i_mem_rd_data)
  );

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d,
                                          logic [BW-1:0] be);
    for (int i = 0; i < BW; i++) if (be[i]) old[8*i +: 8] = d[8*i +: 8];
    return old;
  endfunction

  // ---------------- memory model (registered read) ----------------
  logic [DW-1:0] tb_mem [logic [AW-1:0]];

  always @(posedge clk) begin
    if (o_mem_wr_en != '0)
      tb_mem[o_mem_addr] = merge(tb_mem.exists(o_mem_addr) ? tb_mem[o_mem_addr] : '0,
                                 o_mem_wr_data, o_mem_wr_en);
    if (o_mem_rd_en)
      i_mem_rd_data <= tb_mem.exists(o_mem_addr) ? tb_mem[o_mem_addr] : '0;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] ifu_q[$];
  logic [DW-1:0] lsu_q[$];
  logic ifu_pend = 1'b0, lsu_pend = 1'b0, last_lsu = 1'b1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic ifu_el, lsu_el, ifu_w, lsu_w, ifu_acc, lsu_acc;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, rdv;
    logic [BW-1:0] e_we;
    logic e_rd;
    if (!rst_n) begin
      check("rst_ifu_rsp_valid", o_ifu_rsp_valid, 0);
      check("rst_lsu_rsp_valid", o_lsu_rsp_valid, 0);
      check("rst_ifu_rsp_data", o_ifu_rsp_data, 0);
      check("rst_lsu_rsp_data", o_lsu_rsp_data, 0);
      check("rst_req_ready", {o_ifu_req_ready, o_lsu_req_ready}, 0);
      check("rst_mem_cmd", {o_mem_addr, o_mem_wr_en, o_mem_rd_en}, 0);
      check("rst_mem_wr_data", o_mem_wr_data, 0);
      ifu_q.delete(); lsu_q.delete();
      ifu_pend = 1'b0; lsu_pend = 1'b0; last_lsu = 1'b1;
    end else begin
      check("ifu_rsp_valid", o_ifu_rsp_valid, ifu_pend);
      check("lsu_rsp_valid", o_lsu_rsp_valid, lsu_pend);
      if (o_ifu_rsp_valid) begin
        check("ifu_rsp_expected", ifu_q.size() != 0, 1);
        if (ifu_q.size() != 0) check("ifu_rsp_data", o_ifu_rsp_data, ifu_q[0]);
      end
      if (o_lsu_rsp_valid) begin
        check("lsu_rsp_expected", lsu_q.size() != 0, 1);
        if (lsu_q.size() != 0) check("lsu_rsp_data", o_lsu_rsp_data, lsu_q[0]);
      end
      ifu_acc = ifu_pend && i_ifu_rsp_ready;
      lsu_acc = lsu_pend && i_lsu_rsp_ready;
      ifu_el  = i_ifu_req_valid && (!ifu_pend || i_ifu_rsp_ready);
      lsu_el  = i_lsu_req_valid && (!lsu_pend || i_lsu_rsp_ready);
      ifu_w   = ifu_el && (!lsu_el || last_lsu);
      lsu_w   = lsu_el && (!ifu_el || !last_lsu);
      e_addr = '0; e_wd = '0; e_we = '0; e_rd = 1'b0;
      if (ifu_w) begin
        e_addr = i_ifu_addr; e_rd = 1'b1;
      end else if (lsu_w) begin
        e_addr = i_lsu_addr; e_wd = i_lsu_wr_data; e_we = i_lsu_wr_en;
        e_rd = (i_lsu_wr_en == '0);
      end
      check("ifu_req_ready", o_ifu_req_ready, ifu_w);
      check("lsu_req_ready", o_lsu_req_ready, lsu_w);
      check("mem_addr", o_mem_addr, e_addr);
      check("mem_wr_data", o_mem_wr_data, e_wd);
      check("mem_wr_en", o_mem_wr_en, e_we);
      check("mem_rd_en", o_mem_rd_en, e_rd);
      if (ifu_acc && ifu_q.size() != 0) void'(ifu_q.pop_front());
      if (lsu_acc && lsu_q.size() != 0) void'(lsu_q.pop_front());
      if (ifu_acc) ifu_pend = 1'b0;
      if (lsu_acc) lsu_pend = 1'b0;
      if (ifu_w) begin
        ifu_q.push_back(ref_mem.exists(i_ifu_addr) ? ref_mem[i_ifu_addr] : '0);
        ifu_pend = 1'b1; last_lsu = 1'b0;
      end
      if (lsu_w) begin
        rdv = ref_mem.exists(i_lsu_addr) ? ref_mem[i_lsu_addr] : '0;
        if (i_lsu_wr_en == '0) lsu_q.push_back(rdv);
        else begin
          ref_mem[i_lsu_addr] = merge(rdv, i_lsu_wr_data, i_lsu_wr_en);
          lsu_q.push_back('0);
        end
        lsu_pend = 1'b1; last_lsu = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ifu(logic v, logic [AW-1:0] a, logic r);
    i_ifu_req_valid = v; i_ifu_addr = a; i_ifu_rsp_ready = r;
  endtask

  task automatic set_lsu(logic v, logic [AW-1:0] a, logic [DW-1:0] d,
                         logic [BW-1:0] be, logic r);
    i_lsu_req_valid = v; i_lsu_addr = a; i_lsu_wr_data = d;
    i_lsu_wr_en = be; i_lsu_rsp_ready = r;
  endtask

  task automatic idle(int n);
    set_ifu(0, 0, 1); set_lsu(0, 0, 0, 0, 1);
    repeat (n) next_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] snap10, snap20;
    tb_mem[32'h10] = 32'hDEADBEEF;
    ref_mem[32'h10] = 32'hDEADBEEF;

    // Both ports already requesting when reset releases: expect IFU,LSU,IFU,LSU.
    set_ifu(1, 32'h10, 1); set_lsu(1, 32'h30, 0, 0, 1);
    repeat (3) next_cycle();
    rst_n = 1'b1;
    repeat (4) next_cycle();
    idle(2);

    // Single IFU read.
    set_ifu(1, 32'h10, 1); next_cycle();
    idle(2);

    // LSU write then read.
    set_lsu(1, 32'h20, 32'hCAFEF00D, 4'hF, 1); next_cycle();
    set_lsu(1, 32'h20, 0, 4'h0, 1); next_cycle();
    idle(2);

    // IFU stalled three cycles while LSU reads back-to-back.
    set_ifu(1, 32'h10, 0); set_lsu(0, 0, 0, 0, 1); next_cycle();
    set_lsu(1, 32'h20, 0, 0, 1);
    repeat (3) next_cycle();
    set_ifu(0, 0, 1); next_cycle();
    idle(2);

    // Reset during the FRESH cycle of an LSU read.
    set_lsu(1, 32'h20, 0, 0, 0); next_cycle();
    set_lsu(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    idle(2);
    set_ifu(1, 32'h10, 1); set_lsu(1, 32'h20, 0, 0, 1); next_cycle();
    idle(2);

    // Idle bus for ten cycles: memory must be untouched.
    snap10 = tb_mem[32'h10]; snap20 = tb_mem[32'h20];
    idle(10);
    check("idle_mem_10", tb_mem[32'h10], snap10);
    check("idle_mem_20", tb_mem[32'h20], snap20);

    // Random traffic with random backpressure.
    for (int c = 0; c < 2000; c++) begin
      set_ifu($urandom_range(0, 9) < 7, AW'($urandom_range(1, 4) << 4),
              $urandom_range(0, 9) < 6);
      set_lsu($urandom_range(0, 9) < 7, AW'($urandom_range(1, 4) << 4), $urandom,
              ($urandom_range(0, 1) == 0) ? 4'h0 : BW'($urandom_range(1, 15)),
              $urandom_range(0, 9) < 6);
      next_cycle();
    end
    idle(4);

    check("drain_ifu_q", ifu_q.size(), 0);
    check("drain_lsu_q", lsu_q.size(), 0);
    foreach (ref_mem[a]) check("final_mem", tb_mem[a], ref_mem[a]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
